// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding, word/byte-enable widths,
// and byte-address to word-index conversion.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Valid/ready request and response channels between the MEM-stage initiator (master)
// and the data-memory responder (slave); one outstanding request at a time.
interface dmem_if;

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [dmem_pkg::BE_W-1:0]   req_be;
  logic [31:0]                 req_addr;
  logic [dmem_pkg::WORD_W-1:0] req_wdata;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [dmem_pkg::WORD_W-1:0] rsp_rdata;
  logic                        rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 synchronous RAM with per-byte write enables; one-cycle read.
// Read data is registered only on an enabled read and holds between accesses.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: response LATENCY cycles after accept; one request in flight, so
// req_ready is low from accept until the cycle after the response handshake; response held under backpressure.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              we_q, err_q;
  logic [BE_W-1:0]   be_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;

  logic [29:0]       req_idx;
  logic              req_err, accept, fire;
  logic              a_we, a_err, a_en;
  logic [BE_W-1:0]   a_be;
  logic [AW-1:0]     a_idx;
  logic [WORD_W-1:0] a_wdata, ram_rdata;

  assign req_idx = word_idx(bus.req_addr);
  assign req_err = (bus.req_addr[1:0] != 2'b00) || ({2'b00, req_idx} >= 32'(DEPTH_WORDS));
  assign accept  = (state == IDLE) && bus.req_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0)   state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        if (!err_q && !we_q) bus.rsp_rdata = ram_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= LAT_LOAD;
      we_q    <= bus.req_we;
      err_q   <= req_err;
      be_q    <= bus.req_be;
      idx_q   <= req_idx[AW-1:0];
      wdata_q <= bus.req_wdata;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With LATENCY=1 the access happens on the accept edge itself, so it must use the live request.
  always_comb begin
    if (state == IDLE) begin
      a_we    = bus.req_we;
      a_be    = bus.req_be;
      a_idx   = req_idx[AW-1:0];
      a_wdata = bus.req_wdata;
      a_err   = req_err;
    end else begin
      a_we    = we_q;
      a_be    = be_q;
      a_idx   = idx_q;
      a_wdata = wdata_q;
      a_err   = err_q;
    end
  end

  assign fire = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd0));
  assign a_en = fire && !a_err && !reset;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (a_en),
    .we    (a_we),
    .be    (a_be),
    .idx   (a_idx),
    .wdata (a_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: main instance at LATENCY=2, plus LATENCY=3 (reset in WAIT)
// and LATENCY=1 (back-to-back) instances.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_if m_if ();
  dmem_if l3_if ();
  dmem_if l1_if ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut  (.clk(clk), .reset(reset), .bus(m_if.slave));
  dmem_responder #(.DEPTH_WORDS(64),   .LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(l3_if.slave));
  dmem_responder #(.DEPTH_WORDS(64),   .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(l1_if.slave));

  // Issue one request on the main bus and complete it; called at posedge+1 with the DUT idle.
  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    m_if.req_valid = 1'b1; m_if.req_we = we; m_if.req_be = be;
    m_if.req_addr = addr;  m_if.req_wdata = wdata;
    @(posedge clk); #1;
    m_if.req_valid = 1'b0;
    lat = 0;
    while (m_if.rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    rdata = m_if.rsp_rdata;
    err   = m_if.rsp_err;
    m_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    m_if.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (m_if.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", m_if.req_ready); end
    checks++; if (m_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", m_if.rsp_valid); end
    checks++; if (m_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0", m_if.rsp_rdata); end
    checks++; if (m_if.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", m_if.rsp_err); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rd); end
    do_req(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    do_req(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, er, lat);
    do_req(1'b1, 4'hF, 32'hFFC, 32'h600DD00D, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_wr_err: got %b expected 0", er); end
    do_req(1'b0, 4'hF, 32'hFFC, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h600DD00D) begin errors++; $display("FAIL last_word_rd: got %h expected 600dd00d", rd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 4'b0101, 32'h10, 32'h11223344, rd, er, lat);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be_merge: got %h expected de22be44", rd); end
    do_req(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL be_zero_rsp: got err=%b lat=%0d expected err=0 lat=2", er, lat); end
    do_req(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be_zero_keep: got %h expected de22be44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 4'hF, 32'h12, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_rd: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL misalign_latency: got %0d expected 2", lat); end
    do_req(1'b0, 4'hF, 32'h1000, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL range_rd: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
    do_req(1'b1, 4'hF, 32'h12, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_wr_err: got %b expected 1", er); end
    do_req(1'b1, 4'hF, 32'h1000, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_wr_err: got %b expected 1", er); end
    do_req(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL misalign_no_write: got %h expected de22be44", rd); end
    do_req(1'b0, 4'hF, 32'h0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL range_no_write: got %h expected cafef00d", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    m_if.req_valid = 1'b1; m_if.req_we = 1'b0; m_if.req_be = 4'hF; m_if.req_addr = 32'h10;
    @(posedge clk); #1;
    // keep a conflicting write on the bus while busy; it must be ignored
    m_if.req_we = 1'b1; m_if.req_wdata = 32'h0;
    n = 0;
    while (m_if.rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_latency: got %0d expected 2", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (m_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, m_if.rsp_valid); end
      checks++; if (m_if.rsp_rdata !== 32'hDE22BE44) begin errors++; $display("FAIL bp_rdata[%0d]: got %h expected de22be44", i, m_if.rsp_rdata); end
      checks++; if (m_if.rsp_err !== 1'b0) begin errors++; $display("FAIL bp_err[%0d]: got %b expected 0", i, m_if.rsp_err); end
      checks++; if (m_if.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, m_if.req_ready); end
      @(posedge clk); #1;
    end
    m_if.req_valid = 1'b0;
    m_if.rsp_ready = 1'b1;
    checks++; if (m_if.req_ready !== 1'b0) begin errors++; $display("FAIL hs_cycle_ready: got %b expected 0", m_if.req_ready); end
    @(posedge clk); #1;
    m_if.rsp_ready = 1'b0;
    checks++; if (m_if.req_ready !== 1'b1 || m_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL post_hs: got ready=%b valid=%b expected ready=1 valid=0", m_if.req_ready, m_if.rsp_valid); end
    do_req(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL busy_ignored: got %h expected de22be44", rd); end
  endtask

  task automatic test_reset_wait();
    int n;
    l3_if.req_valid = 1'b1; l3_if.req_we = 1'b1; l3_if.req_be = 4'hF;
    l3_if.req_addr = 32'h20; l3_if.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    l3_if.req_valid = 1'b0;
    n = 0;
    while (l3_if.rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL l3_wr_latency: got %0d expected 3", n); end
    l3_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    l3_if.rsp_ready = 1'b0;
    l3_if.req_valid = 1'b1; l3_if.req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    l3_if.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (l3_if.req_ready !== 1'b1 || l3_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL l3_rst_hs: got ready=%b valid=%b expected ready=1 valid=0", l3_if.req_ready, l3_if.rsp_valid); end
    checks++; if (l3_if.rsp_rdata !== 32'h0 || l3_if.rsp_err !== 1'b0) begin errors++; $display("FAIL l3_rst_rsp: got rdata=%h err=%b expected 0/0", l3_if.rsp_rdata, l3_if.rsp_err); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (l3_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL l3_no_late_rsp: got %b expected 0", l3_if.rsp_valid); end
    l3_if.req_valid = 1'b1; l3_if.req_we = 1'b0;
    @(posedge clk); #1;
    l3_if.req_valid = 1'b0;
    n = 0;
    while (l3_if.rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL l3_rd_latency: got %0d expected 3", n); end
    checks++; if (l3_if.rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL l3_discarded_wr: got %h expected 12345678", l3_if.rsp_rdata); end
    l3_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    l3_if.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int resp_cnt = 0;
    l1_if.rsp_ready = 1'b1;
    l1_if.req_valid = 1'b1; l1_if.req_we = 1'b1; l1_if.req_be = 4'hF;
    l1_if.req_addr = 32'h4; l1_if.req_wdata = 32'h0BADCAFE;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (l1_if.rsp_valid === 1'b1) resp_cnt++;
      checks++; if (l1_if.rsp_valid !== ((i % 2) == 0)) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %0d", i, l1_if.rsp_valid, (i % 2) == 0); end
      if (i == 0) begin
        checks++; if (l1_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_wr_rdata: got %h expected 0", l1_if.rsp_rdata); end
        l1_if.req_we = 1'b0;
      end
      if (i == 2 || i == 4) begin
        checks++; if (l1_if.rsp_rdata !== 32'h0BADCAFE) begin errors++; $display("FAIL b2b_rd_rdata[%0d]: got %h expected 0badcafe", i, l1_if.rsp_rdata); end
      end
    end
    l1_if.req_valid = 1'b0;
    l1_if.rsp_ready = 1'b0;
    checks++; if (resp_cnt !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", resp_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    m_if.req_valid = 1'b0;  m_if.req_we = 1'b0;  m_if.req_be = 4'h0;  m_if.req_addr = 32'h0;  m_if.req_wdata = 32'h0;  m_if.rsp_ready = 1'b0;
    l3_if.req_valid = 1'b0; l3_if.req_we = 1'b0; l3_if.req_be = 4'h0; l3_if.req_addr = 32'h0; l3_if.req_wdata = 32'h0; l3_if.rsp_ready = 1'b0;
    l1_if.req_valid = 1'b0; l1_if.req_we = 1'b0; l1_if.req_be = 4'h0; l1_if.req_addr = 32'h0; l1_if.req_wdata = 32'h0; l1_if.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_reset_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the data array.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to rsp_valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator (MEM stage) presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_be  input  4  byte enables for writes; bit i selects wdata[8i+7:8i].
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-013 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding request maximum.
REQ-016 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 SHALL accept a request on a rising edge where req_valid && req_ready, capturing we, be, addr and wdata into internal registers.
REQ-018 SHALL, on accept, load a latency counter with LATENCY-1 and enter WAIT; SHALL decrement the counter each cycle in WAIT.
REQ-019 SHALL, for LATENCY=1, go from accept directly to RESP, skipping WAIT.
REQ-020 SHALL perform the array access and enter RESP on the edge where the counter is 0, so that rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-021 SHALL index the array by addr[31:2]; a read returns the full word regardless of be.
REQ-022 SHALL write only the enabled bytes; be=4'b0000 SHALL leave the array unchanged and still produce a normal response.
REQ-023 SHALL flag an error when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; on error SHALL perform no array access and SHALL return rsp_err=1 and rsp_rdata=0.
REQ-024 SHALL hold rsp_rdata and rsp_err stable while rsp_valid=1 && rsp_ready=0.
REQ-025 SHALL return to IDLE on the edge where rsp_valid && rsp_ready; req_ready SHALL rise the following cycle (no same-cycle accept in RESP).
REQ-026 SHALL make a write visible to any subsequently accepted read (read-after-write coherent).
REQ-027 SHALL ignore req_* inputs in WAIT and RESP.

Reset
REQ-028 SHALL, when reset=1 at a rising edge, force state IDLE, counter 0, req_ready=1 (from the next cycle), rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 SHALL, on reset during WAIT, discard the captured request; a pending write SHALL NOT modify the array.
REQ-030 SHALL NOT clear array contents on reset.

Structure
REQ-031 SHALL place the state encoding typedef, word/byte-enable width constants and the address word-index function in shared package dmem_pkg.
REQ-032 SHALL instantiate one sub-module, dmem_array: single-port, byte-enabled, DEPTH_WORDS x 32 synchronous RAM.

Verification
REQ-033 SHALL cover: write addr 0x10, wdata 0xDEADBEEF, be=4'hF, then read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly LATENCY cycles after each accept.
REQ-034 SHALL cover: write 0x10 wdata 0x11223344 be=4'b0101 over 0xDEADBEEF, read back -> 0xDE22BE44.
REQ-035 SHALL cover: read addr 0x12 and read addr 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, array unchanged.
REQ-036 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0 throughout; req_ready=1 the cycle after the handshake.
REQ-037 SHALL cover: reset asserted one cycle after accepting write 0x20 (LATENCY=3) -> outputs at reset values, subsequent read 0x20 returns the prior contents.
REQ-038 SHALL cover: LATENCY=1 build -> back-to-back requests with rsp_ready=1 give one response every 2 cycles.
